// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit: shift-add multiply (LSB first) and
// restoring divide (MSB first), one bit per cycle, sitting beside the ALU.
module mul_div_unit #(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         zero
);

   // state | meaning
   // IDLE  | waiting for start, busy=0 done=0
   // RUN   | one multiplier/quotient bit per edge, busy=1
   // DONE  | result valid, done pulse, new start accepted
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int CW = $clog2(N);

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [1:0]      op_q, op_d;
   logic [N-1:0]    opnd_q, opnd_d;
   logic [2*N-1:0]  acc_q, acc_d;
   logic [N-1:0]    rem_q, rem_d;
   logic [N-1:0]    result_q, result_d;
   logic            zero_q, zero_d;

   logic [N:0]      mul_sum;
   logic [2*N-1:0]  mul_next;
   logic [N:0]      div_shift;
   logic [N:0]      div_diff;
   logic            div_ge;
   logic [N-1:0]    rem_next;
   logic [N-1:0]    quo_next;
   logic [2*N-1:0]  step_acc;
   logic [N-1:0]    fin_result;

   // Multiply: acc = {partial product, remaining multiplier bits}.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
      mul_next = {mul_sum, acc_q[N-1:1]};
   end

   // Divide: the remainder stays below the divisor, so a set borrow bit in the
   // N+1-bit difference means the trial subtraction failed.
   always_comb begin
      div_shift = {rem_q, acc_q[N-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      div_ge    = ~div_diff[N];
      rem_next  = div_ge ? div_diff[N-1:0] : div_shift[N-1:0];
      quo_next  = {acc_q[N-2:0], div_ge};
   end

   always_comb begin
      step_acc = op_q[1] ? {acc_q[2*N-1:N], quo_next} : mul_next;
      case (op_q)
         2'b00:   fin_result = mul_next[N-1:0];
         2'b01:   fin_result = mul_next[2*N-1:N];
         2'b10:   fin_result = quo_next;
         default: fin_result = rem_next;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      op_d     = op_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      rem_d    = rem_q;
      result_d = result_q;
      zero_d   = zero_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               op_d    = op;
               count_d = '0;
               rem_d   = '0;
               if (op[1]) begin
                  opnd_d = b;
                  acc_d  = {{N{1'b0}}, a};
                  if (b == '0) begin
                     // Divide by zero: quotient 0, remainder = dividend.
                     state_d  = DONE;
                     result_d = op[0] ? a : '0;
                     zero_d   = op[0] ? (a == '0) : 1'b1;
                  end else begin
                     state_d = RUN;
                  end
               end else begin
                  opnd_d  = a;
                  acc_d   = {{N{1'b0}}, b};
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            acc_d = step_acc;
            rem_d = rem_next;
            if (count_q == CW'(N-1)) begin
               state_d  = DONE;
               result_d = fin_result;
               zero_d   = (fin_result == '0);
            end else begin
               count_d = count_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         op_q     <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         op_q     <= op_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);
   assign result = result_q;
   assign zero   = zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed and randomized ops checked against a plain
// arithmetic reference, plus latency, back-to-back, ignored start and reset.
module tb_mul_div_unit;
   localparam int N = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic         zero;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mul_div_unit #(.N(N)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .zero   (zero)
   );

   function automatic logic [N-1:0] ref_result(input logic [1:0] o, input logic [N-1:0] x,
                                                input logic [N-1:0] y);
      logic [2*N-1:0] p;
      p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
      case (o)
         2'd0:    return p[N-1:0];
         2'd1:    return p[2*N-1:N];
         2'd2:    return (y == '0) ? '0 : x / y;
         default: return (y == '0) ? x : x % y;
      endcase
   endfunction

   function automatic logic [N-1:0] rand_word();
      return {$urandom, $urandom};
   endfunction

   // Issues one op and waits (bounded) for done; measures, does not judge.
   task automatic issue(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                        input bit scramble, output int lat, output int busy_cnt,
                        output bit held, output bit timeout);
      logic [N-1:0] prev;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      prev = result;
      @(negedge clk);
      start = 1'b0;
      lat = 1; busy_cnt = 0; held = 1'b1; timeout = 1'b0;
      while (!done && lat < 200) begin
         if (busy) busy_cnt++;
         if (result !== prev) held = 1'b0;
         if (scramble) begin
            a = rand_word(); b = rand_word();
            op = 2'($urandom_range(0, 3));
            start = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      if (!done) timeout = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || zero !== 1'b1) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d: busy=%b done=%b result=%h zero=%b, want 0 0 0 1",
                     i, busy, done, result, zero);
         end
      end
   endtask

   task automatic test_mul();
      int lat, bc; bit held, to;
      logic [N-1:0] x, exp;
      x = '1;
      for (int o = 0; o < 2; o++) begin
         issue(2'(o), x, 64'd2, 1'b0, lat, bc, held, to);
         exp = (o == 0) ? 64'hFFFF_FFFF_FFFF_FFFE : 64'h1;
         total++;
         if (to || lat !== N + 1) begin
            bad++; $display("FAIL mul_latency op=%0d: got %0d want %0d", o, lat, N + 1);
         end
         total++;
         if (bc !== N) begin
            bad++; $display("FAIL mul_busy_cycles op=%0d: got %0d want %0d", o, bc, N);
         end
         total++;
         if (result !== exp || zero !== 1'b0) begin
            bad++; $display("FAIL mul_result op=%0d: got %h z=%b want %h z=0", o, result, zero, exp);
         end
      end
   endtask

   task automatic test_div();
      int lat, bc; bit held, to;
      logic [N-1:0] exp;
      for (int o = 2; o < 4; o++) begin
         issue(2'(o), 64'd100, 64'd7, 1'b1, lat, bc, held, to);
         exp = (o == 2) ? 64'd14 : 64'd2;
         total++;
         if (to || lat !== N + 1) begin
            bad++; $display("FAIL div_latency op=%0d: got %0d want %0d", o, lat, N + 1);
         end
         total++;
         if (result !== exp || zero !== 1'b0) begin
            bad++; $display("FAIL div_result op=%0d: got %0d z=%b want %0d z=0", o, result, zero, exp);
         end
         total++;
         if (!held) begin
            bad++; $display("FAIL div_hold op=%0d: result changed during RUN, want held", o);
         end
      end
   endtask

   task automatic test_div_zero();
      int lat, bc; bit held, to;
      logic [N-1:0] exp;
      for (int o = 2; o < 4; o++) begin
         issue(2'(o), 64'd55, 64'd0, 1'b0, lat, bc, held, to);
         exp = (o == 2) ? 64'd0 : 64'd55;
         total++;
         if (to || lat !== 1 || bc !== 0 || busy !== 1'b0) begin
            bad++; $display("FAIL div0_timing op=%0d: lat=%0d busy_cnt=%0d busy=%b want 1 0 0",
                            o, lat, bc, busy);
         end
         total++;
         if (result !== exp || zero !== (exp == '0)) begin
            bad++; $display("FAIL div0_result op=%0d: got %0d z=%b want %0d z=%b",
                            o, result, zero, exp, (exp == '0));
         end
      end
   endtask

   task automatic test_random();
      int lat, bc; bit held, to;
      logic [1:0] o;
      logic [N-1:0] x, y, exp;
      bit dz;
      for (int i = 0; i < 24; i++) begin
         o = 2'($urandom_range(0, 3));
         x = rand_word();
         y = rand_word() >> $urandom_range(0, 63);
         if ($urandom_range(0, 7) == 0) y = '0;
         if ($urandom_range(0, 5) == 0) x = x >> $urandom_range(40, 63);
         issue(o, x, y, 1'($urandom_range(0, 1)), lat, bc, held, to);
         exp = ref_result(o, x, y);
         dz  = o[1] && (y == '0);
         total++;
         if (to || lat !== (dz ? 1 : N + 1) || bc !== (dz ? 0 : N)) begin
            bad++; $display("FAIL rand_timing #%0d op=%0d: lat=%0d busy_cnt=%0d want %0d %0d",
                            i, o, lat, bc, dz ? 1 : N + 1, dz ? 0 : N);
         end
         total++;
         if (result !== exp || zero !== (exp == '0) || !held) begin
            bad++; $display("FAIL rand_result #%0d op=%0d a=%h b=%h: got %h z=%b held=%b want %h z=%b",
                            i, o, x, y, result, zero, held, exp, (exp == '0));
         end
      end
   endtask

   task automatic test_back_to_back();
      int n, prev_n, pulses;
      @(negedge clk);
      start = 1'b1; op = 2'd0; a = 64'd3; b = 64'd5;
      n = 0; prev_n = 0; pulses = 0;
      while (pulses < 3 && n < 400) begin
         @(negedge clk);
         n++;
         if (done) begin
            pulses++;
            total++;
            if (n - prev_n !== N + 1 || result !== 64'd15 || zero !== 1'b0) begin
               bad++; $display("FAIL b2b_pulse %0d: interval=%0d result=%0d z=%b want %0d 15 0",
                               pulses, n - prev_n, result, zero, N + 1);
            end
            prev_n = n;
            if (pulses == 3) start = 1'b0;
         end
      end
      total++;
      if (pulses !== 3) begin
         bad++; $display("FAIL b2b_count: got %0d pulses want 3", pulses);
      end
      start = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL b2b_idle: busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_reset_mid();
      int done_seen, busy_seen;
      @(negedge clk);
      start = 1'b1; op = 2'd2; a = rand_word(); b = 64'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      total++;
      if (busy !== 1'b1 || result === '0) begin
         bad++; $display("FAIL mid_pre: busy=%b result=%h want busy=1 and nonzero held result",
                         busy, result);
      end
      reset = 1'b1;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || zero !== 1'b1) begin
         bad++; $display("FAIL mid_reset: busy=%b done=%b result=%h zero=%b want 0 0 0 1",
                         busy, done, result, zero);
      end
      reset = 1'b0;
      done_seen = 0; busy_seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) done_seen++;
         if (busy) busy_seen++;
      end
      total++;
      if (done_seen !== 0 || busy_seen !== 0) begin
         bad++; $display("FAIL mid_abort: done cycles=%0d busy cycles=%0d want 0 0", done_seen, busy_seen);
      end
      reset = 1'b1; start = 1'b1; op = 2'd0; a = 64'd9; b = 64'd9;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
         bad++; $display("FAIL reset_vs_start: busy=%b done=%b result=%h want 0 0 0", busy, done, result);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_zero();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
